// File: rtl/mem_arbiter_pkg.sv
// mem_arbiter_pkg: shared state encoding, memory select codes and requester indices
package mem_arbiter_pkg;
    typedef enum logic [1:0] {IDLE, PRE, ACC, REC} state_e;
    localparam logic [2:0] SEL_EPC = 3'b001;
    localparam logic [2:0] SEL_S1  = 3'b010;
    localparam logic [2:0] SEL_S2  = 3'b100;
    localparam int REQ_SW = 0;
    localparam int REQ_EW = 1;
    localparam int REQ_RD = 2;
    function automatic logic sel_ok(input logic [2:0] s);
        return s == SEL_EPC || s == SEL_S1 || s == SEL_S2;
    endfunction
endpackage

// File: rtl/mem_arbiter_prio_sel.sv
// mem_prio_sel: fixed sw > ew > rd priority with a starvation override for rd, one-hot grant
module mem_prio_sel
    import mem_arbiter_pkg::*;
#(
    parameter int STARVE_LIMIT = 3,
    parameter int CW = 2
) (
    input  logic [2:0]    req_i,
    input  logic [CW-1:0] starve_i,
    output logic [2:0]    gnt_o
);
    logic starved;
    assign starved = req_i[REQ_RD] && starve_i == CW'(STARVE_LIMIT);
    always_comb begin
        gnt_o = '0;
        if (starved) gnt_o[REQ_RD] = 1'b1;
        else if (req_i[REQ_SW]) gnt_o[REQ_SW] = 1'b1;
        else if (req_i[REQ_EW]) gnt_o[REQ_EW] = 1'b1;
        else if (req_i[REQ_RD]) gnt_o[REQ_RD] = 1'b1;
    end
endmodule

// File: rtl/mem_arbiter.sv
// mem_arbiter: three-requester arbiter driving a precharge/access/recover memory macro sequence
module mem_arbiter
    import mem_arbiter_pkg::*;
#(
    parameter int STARVE_LIMIT = 3,
    parameter int ADDR_W = 6
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              sw_req,
    input  logic [ADDR_W-1:0] sw_addr,
    input  logic [2:0]        sw_sel,
    input  logic [15:0]       sw_data,
    output logic              sw_done,
    input  logic              ew_req,
    input  logic [ADDR_W-1:0] ew_addr,
    input  logic [15:0]       ew_data,
    output logic              ew_done,
    input  logic              rd_req,
    input  logic [ADDR_W-1:0] rd_addr,
    input  logic [2:0]        rd_sel,
    output logic [15:0]       rd_data,
    output logic              rd_done,
    output logic              PC_B,
    output logic              WE,
    output logic              SE,
    output logic [ADDR_W-1:0] mem_address,
    output logic [2:0]        mem_sel,
    output logic [15:0]       mem_data_out,
    input  logic [15:0]       mem_read_in,
    output logic              busy,
    output logic              err
);
    localparam int CW = STARVE_LIMIT < 1 ? 1 : $clog2(STARVE_LIMIT + 1);

    state_e            state_q;
    logic [CW-1:0]     starve_q, starve_d;
    logic [2:0]        gnt_q, gnt;
    logic [15:0]       data_q;
    logic              ok_q;
    logic [ADDR_W-1:0] req_addr;
    logic [2:0]        req_sel;
    logic [15:0]       req_data;

    mem_prio_sel #(.STARVE_LIMIT(STARVE_LIMIT), .CW(CW)) u_prio (
        .req_i    ({rd_req, ew_req, sw_req}),
        .starve_i (starve_q),
        .gnt_o    (gnt)
    );

    // Starvation only accrues while rd is actually waiting; only applied on an IDLE grant.
    always_comb begin
        req_addr = gnt[REQ_SW] ? sw_addr : gnt[REQ_EW] ? ew_addr : rd_addr;
        req_sel  = gnt[REQ_SW] ? sw_sel : gnt[REQ_EW] ? SEL_EPC : rd_sel;
        req_data = gnt[REQ_SW] ? sw_data : ew_data;
        starve_d = gnt[REQ_RD] ? '0 :
                   (rd_req && starve_q != CW'(STARVE_LIMIT)) ? starve_q + CW'(1) : starve_q;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= IDLE;
            starve_q     <= '0;
            gnt_q        <= '0;
            data_q       <= '0;
            ok_q         <= 1'b0;
            PC_B         <= 1'b1;
            WE           <= 1'b0;
            SE           <= 1'b0;
            mem_address  <= '0;
            mem_sel      <= '0;
            mem_data_out <= '0;
            sw_done      <= 1'b0;
            ew_done      <= 1'b0;
            rd_done      <= 1'b0;
            rd_data      <= '0;
            busy         <= 1'b0;
            err          <= 1'b0;
        end else begin
            case (state_q)
                IDLE: if (|gnt) begin
                    state_q     <= PRE;
                    starve_q    <= starve_d;
                    gnt_q       <= gnt;
                    data_q      <= req_data;
                    ok_q        <= sel_ok(req_sel);
                    PC_B        <= 1'b0;
                    mem_address <= req_addr;
                    mem_sel     <= req_sel;
                    busy        <= 1'b1;
                end
                PRE: begin
                    state_q      <= ACC;
                    PC_B         <= 1'b1;
                    WE           <= ok_q && !gnt_q[REQ_RD];
                    SE           <= ok_q && gnt_q[REQ_RD];
                    mem_data_out <= gnt_q[REQ_RD] ? '0 : data_q;
                end
                ACC: begin
                    state_q      <= REC;
                    WE           <= 1'b0;
                    SE           <= 1'b0;
                    mem_data_out <= '0;
                    sw_done      <= gnt_q[REQ_SW];
                    ew_done      <= gnt_q[REQ_EW];
                    rd_done      <= gnt_q[REQ_RD];
                    err          <= !ok_q;
                    if (gnt_q[REQ_RD] && ok_q) rd_data <= mem_read_in;
                end
                REC: begin
                    state_q     <= IDLE;
                    gnt_q       <= '0;
                    sw_done     <= 1'b0;
                    ew_done     <= 1'b0;
                    rd_done     <= 1'b0;
                    err         <= 1'b0;
                    busy        <= 1'b0;
                    mem_address <= '0;
                    mem_sel     <= '0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: transaction-level model checked every cycle plus directed literal checks
module tb_mem_arbiter;
    localparam int LIM = 3;
    localparam int AW = 6;

    logic          clk = 1'b0, reset = 1'b1;
    logic          sw_req = 0, ew_req = 0, rd_req = 0;
    logic [AW-1:0] sw_addr = 0, ew_addr = 0, rd_addr = 0;
    logic [2:0]    sw_sel = 0, rd_sel = 0;
    logic [15:0]   sw_data = 0, ew_data = 0, mem_read_in = 0;
    logic          sw_done, ew_done, rd_done, PC_B, WE, SE, busy, err;
    logic [15:0]   rd_data, mem_data_out;
    logic [AW-1:0] mem_address;
    logic [2:0]    mem_sel;

    int checks = 0, errors = 0;

    mem_arbiter #(.STARVE_LIMIT(LIM), .ADDR_W(AW)) dut (
        .clk(clk), .reset(reset),
        .sw_req(sw_req), .sw_addr(sw_addr), .sw_sel(sw_sel), .sw_data(sw_data), .sw_done(sw_done),
        .ew_req(ew_req), .ew_addr(ew_addr), .ew_data(ew_data), .ew_done(ew_done),
        .rd_req(rd_req), .rd_addr(rd_addr), .rd_sel(rd_sel), .rd_data(rd_data), .rd_done(rd_done),
        .PC_B(PC_B), .WE(WE), .SE(SE), .mem_address(mem_address), .mem_sel(mem_sel),
        .mem_data_out(mem_data_out), .mem_read_in(mem_read_in), .busy(busy), .err(err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    // Model: cycles elapsed since the grant (0 = idle, 1..3 = precharge/access/recover).
    int            mph = 0, mwho = 0, mstarve = 0;
    logic [AW-1:0] maddr = 0;
    logic [2:0]    msel = 0;
    logic [15:0]   mdata = 0, mrd = 0;
    logic          mok = 0;

    always @(posedge clk) begin
        if (reset) begin
            mph = 0; mstarve = 0; mrd = 0;
        end else if (mph == 0) begin
            if (sw_req || ew_req || rd_req) begin
                if (rd_req && mstarve == LIM) mwho = 2;
                else if (sw_req) mwho = 0;
                else if (ew_req) mwho = 1;
                else mwho = 2;
                if (mwho == 2) mstarve = 0;
                else if (rd_req && mstarve < LIM) mstarve++;
                maddr = mwho == 0 ? sw_addr : mwho == 1 ? ew_addr : rd_addr;
                msel  = mwho == 0 ? sw_sel : mwho == 1 ? 3'b001 : rd_sel;
                mdata = mwho == 0 ? sw_data : ew_data;
                mok   = msel inside {3'b001, 3'b010, 3'b100};
                mph   = 1;
            end
        end else begin
            if (mph == 2 && mwho == 2 && mok) mrd = mem_read_in;
            mph = (mph + 1) % 4;
        end
    end

    always @(negedge clk) begin
        chk("PC_B", PC_B, mph != 1);
        chk("WE", WE, mph == 2 && mwho != 2 && mok);
        chk("SE", SE, mph == 2 && mwho == 2 && mok);
        chk("mem_address", mem_address, mph != 0 ? maddr : '0);
        chk("mem_sel", mem_sel, mph != 0 ? msel : 3'b000);
        chk("mem_data_out", mem_data_out, (mph == 2 && mwho != 2) ? mdata : 16'h0);
        chk("sw_done", sw_done, mph == 3 && mwho == 0);
        chk("ew_done", ew_done, mph == 3 && mwho == 1);
        chk("rd_done", rd_done, mph == 3 && mwho == 2);
        chk("err", err, mph == 3 && !mok);
        chk("busy", busy, mph != 0);
        chk("rd_data", rd_data, mrd);
    end

    int log_q[$];
    logic log_en = 0;
    always @(negedge clk) if (log_en) begin
        if (sw_done) log_q.push_back(0);
        if (ew_done) log_q.push_back(1);
        if (rd_done) log_q.push_back(2);
    end

    task automatic step();
        @(negedge clk);
        #2;
    endtask

    int exp_order[8] = '{0, 1, 0, 2, 0, 0, 0, 2};
    int sw_hold, t1, t2;

    initial begin
        step(); step();
        chk("reset PC_B", PC_B, 1);
        chk("reset busy", busy, 0);
        chk("reset rd_data", rd_data, 0);
        chk("reset mem_sel", mem_sel, 0);
        reset = 0;
        step();

        sw_req = 1; sw_addr = 5; sw_sel = 3'b010; sw_data = 16'hA55A;
        step();
        chk("t1 PC_B N+1", PC_B, 0);
        chk("t1 addr N+1", mem_address, 5);
        step();
        chk("t1 WE N+2", WE, 1);
        chk("t1 data N+2", mem_data_out, 16'hA55A);
        step();
        chk("t1 sw_done N+3", sw_done, 1);
        sw_req = 0;
        step();
        chk("t1 busy idle", busy, 0);

        rd_req = 1; rd_addr = 2; rd_sel = 3'b001;
        step();
        chk("t2 SE N+1", SE, 0);
        mem_read_in = 16'h3001;
        step();
        chk("t2 SE N+2", SE, 1);
        step();
        chk("t2 rd_done N+3", rd_done, 1);
        chk("t2 rd_data", rd_data, 16'h3001);
        chk("t2 SE N+3", SE, 0);
        rd_req = 0; mem_read_in = 16'h0;
        step(); step();
        chk("t2 rd_data hold", rd_data, 16'h3001);

        log_en = 1; sw_hold = 0;
        sw_sel = 3'b100; sw_data = 16'h1111; ew_addr = 9; ew_data = 16'h2222;
        rd_sel = 3'b001; mem_read_in = 16'h0BAD;
        sw_req = 1; ew_req = 1; rd_req = 1;
        for (int i = 0; i < 60 && log_q.size() < 8; i++) begin
            step();
            if (sw_hold > 0) begin
                sw_hold--;
                if (sw_hold == 0) sw_req = 1;
            end
            if (sw_done && log_q.size() == 1) begin
                sw_req = 0;
                sw_hold = 2;
            end
        end
        sw_req = 0; ew_req = 0; rd_req = 0; log_en = 0; mem_read_in = 0;
        chk("t3 grant count", log_q.size(), 8);
        for (int i = 0; i < 8; i++)
            chk($sformatf("t3 grant %0d", i), i < log_q.size() ? log_q[i] : -1, exp_order[i]);
        step();

        sw_req = 1; sw_addr = 3; sw_sel = 3'b011; sw_data = 16'h1234;
        step(); step();
        chk("t4 WE N+2", WE, 0);
        step();
        chk("t4 err N+3", err, 1);
        chk("t4 sw_done N+3", sw_done, 1);
        sw_req = 0;
        step();

        sw_req = 1; sw_addr = 1; sw_sel = 3'b010; sw_data = 16'h5A5A;
        step(); step();
        chk("t5 WE in ACC", WE, 1);
        reset = 1;
        step();
        chk("t5 WE after reset", WE, 0);
        chk("t5 PC_B after reset", PC_B, 1);
        chk("t5 busy after reset", busy, 0);
        chk("t5 no sw_done", sw_done, 0);
        reset = 0; sw_req = 0;
        step();
        chk("t5 no sw_done later", sw_done, 0);

        ew_req = 1; ew_addr = 7; ew_data = 16'hBEEF;
        t1 = -1; t2 = -1;
        for (int i = 0; i < 20 && t2 < 0; i++) begin
            step();
            if (ew_done) begin
                if (t1 < 0) t1 = i;
                else begin t2 = i; ew_req = 0; end
            end
        end
        ew_req = 0;
        if (t2 < 0) begin
            errors++;
            $display("FAIL t6 timeout: second ew_done not seen, first at %0d", t1);
        end
        chk("t6 first latency", t1, 2);
        chk("t6 done spacing", t2 - t1, 4);
        step(); step();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
